branch_redirect_controller: RTL and testbench

- Sequences control-flow redirects from the EX-stage branch resolution into the fetch PC mux and the pipeline flush lines.
- Computes the branch target and holds a taken redirect across stalls using an explicit valid state, so a target of 0x00000000 is legal.
- Drives multi-cycle IF/ID squash and one-cycle ID/EX squash, flags misaligned targets, and counts issued redirects.
- Sits between the EX stage, hazard unit and PC register.

---
 rtl/branch_redirect_controller.sv | 105 ++++++++++
 tb/tb_branch_redirect_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_controller.sv
// rtl/branch_redirect_controller.sv - EX-stage branch redirect sequencer
// Issues, holds and flushes control-flow redirects; counts issued redirects.
module branch_redirect_controller #(
   parameter int FLUSH_CYCLES = 2,
   parameter int COUNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               fetchReady,
   input  logic               branchValid,
   input  logic               branchTaken,
   input  logic [31:0]        branchPc,
   input  logic [31:0]        branchImm,
   output logic               redirectValid,
   output logic [31:0]        redirectTarget,
   output logic               flushIfId,
   output logic               flushIdEx,
   output logic               misalignedTrap,
   output logic               busy,
   output logic [COUNT_W-1:0] redirectCount
);

   typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

   state_t      state;
   logic [31:0] heldTarget;
   logic [31:0] sumTarget;
   logic [31:0] curTarget;
   logic [3:0]  flushCnt;
   logic        takenBranch;
   logic        canIssue;
   logic        issue;
   logic        misaligned;

   assign sumTarget   = branchPc + branchImm;
   assign takenBranch = branchValid && branchTaken;
   assign canIssue    = !stall && fetchReady;
   assign curTarget   = (state == HOLD) ? heldTarget : sumTarget;
   assign misaligned  = curTarget[1:0] != 2'b00;

   // Issue is combinational from the inputs, so it is gated by reset to keep outputs quiet.
   always_comb begin
      issue = 1'b0;
      case (state)
         IDLE:    issue = takenBranch && canIssue;
         HOLD:    issue = canIssue;
         default: issue = 1'b0;
      endcase
      issue = issue && rst_n;
   end

   assign redirectValid  = issue && !misaligned;
   assign misalignedTrap = issue && misaligned;
   assign flushIfId      = issue || (state == FLUSH);
   assign flushIdEx      = issue;
   assign busy           = state != IDLE;
   assign redirectTarget = (rst_n && (issue || state == HOLD)) ? curTarget : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         heldTarget    <= 32'h0;
         flushCnt      <= 4'd0;
         redirectCount <= '0;
      end else begin
         if (redirectValid && redirectCount != {COUNT_W{1'b1}})
            redirectCount <= redirectCount + COUNT_W'(1);
         case (state)
            IDLE, HOLD: begin
               if (issue) begin
                  if (FLUSH_CYCLES == 1) begin
                     state    <= IDLE;
                     flushCnt <= 4'd0;
                  end else begin
                     state    <= FLUSH;
                     flushCnt <= FLUSH_INIT;
                  end
               end else if (state == IDLE && takenBranch) begin
                  state      <= HOLD;
                  heldTarget <= sumTarget;
               end
            end
            FLUSH: begin
               // Countdown freezes while stalled; branch inputs are squashed bubbles here.
               if (!stall) begin
                  if (flushCnt <= 4'd1) begin
                     state    <= IDLE;
                     flushCnt <= 4'd0;
                  end else begin
                     flushCnt <= flushCnt - 4'd1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               flushCnt <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_redirect_controller.sv
// tb/tb_branch_redirect_controller.sv - directed vectors and sequences for branch_redirect_controller
module tb_branch_redirect_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, fetchReady, branchValid, branchTaken;
   logic [31:0] branchPc, branchImm;

   logic        rv0, fif0, fex0, mis0, busy0;
   logic [31:0] tgt0;
   logic [15:0] cnt0;
   logic        rv1, fif1, fex1, mis1, busy1;
   logic [31:0] tgt1;
   logic [1:0]  cnt1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_redirect_controller #(.FLUSH_CYCLES(2), .COUNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .fetchReady(fetchReady),
      .branchValid(branchValid), .branchTaken(branchTaken),
      .branchPc(branchPc), .branchImm(branchImm),
      .redirectValid(rv0), .redirectTarget(tgt0), .flushIfId(fif0),
      .flushIdEx(fex0), .misalignedTrap(mis0), .busy(busy0), .redirectCount(cnt0)
   );

   branch_redirect_controller #(.FLUSH_CYCLES(3), .COUNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .fetchReady(fetchReady),
      .branchValid(branchValid), .branchTaken(branchTaken),
      .branchPc(branchPc), .branchImm(branchImm),
      .redirectValid(rv1), .redirectTarget(tgt1), .flushIfId(fif1),
      .flushIdEx(fex1), .misalignedTrap(mis1), .busy(busy1), .redirectCount(cnt1)
   );

   typedef struct {
      logic        st, fr, bv, bt;
      logic [31:0] pc, imm;
      logic        rv;
      logic [31:0] tgt;
      logic        fif, fex, mis;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic clearIn();
      stall = 0; fetchReady = 1; branchValid = 0; branchTaken = 0;
      branchPc = 32'h0; branchImm = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      clearIn();
      rst_n = 0;
      step();
      rst_n = 1;
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] imm);
      branchValid = 1; branchTaken = 1; branchPc = pc; branchImm = imm;
   endtask

   initial begin
      int ifCount;
      int rvExtra;
      int leaked;

      vecs[0] = '{0, 1, 1, 1, 32'h100,      32'h20,       1, 32'h120, 1, 1, 0};
      vecs[1] = '{0, 1, 1, 1, 32'hFFFFFFFC, 32'h8,        1, 32'h4,   1, 1, 0};
      vecs[2] = '{0, 1, 1, 1, 32'h100,      32'h2,        0, 32'h0,   1, 1, 1};
      vecs[3] = '{1, 1, 1, 1, 32'h100,      32'h20,       0, 32'h0,   0, 0, 0};
      vecs[4] = '{0, 0, 1, 1, 32'h100,      32'h20,       0, 32'h0,   0, 0, 0};
      vecs[5] = '{0, 1, 1, 0, 32'h100,      32'h20,       0, 32'h0,   0, 0, 0};
      vecs[6] = '{0, 1, 0, 1, 32'h100,      32'h20,       0, 32'h0,   0, 0, 0};
      vecs[7] = '{0, 1, 1, 1, 32'h8,        32'hFFFFFFF8, 1, 32'h0,   1, 1, 0};

      clearIn();
      rst_n = 0;
      #1;
      check("reset_rv", {31'b0, rv0}, 0);
      check("reset_flushIfId", {31'b0, fif0}, 0);
      check("reset_busy", {31'b0, busy0}, 0);
      check("reset_count", {16'b0, cnt0}, 0);
      step();
      rst_n = 1;
      #1;

      // Single-cycle response from IDLE
      for (int i = 0; i < 8; i++) begin
         doReset();
         stall = vecs[i].st; fetchReady = vecs[i].fr;
         branchValid = vecs[i].bv; branchTaken = vecs[i].bt;
         branchPc = vecs[i].pc; branchImm = vecs[i].imm;
         #1;
         check($sformatf("vec%0d_rv", i), {31'b0, rv0}, {31'b0, vecs[i].rv});
         if (vecs[i].rv)
            check($sformatf("vec%0d_tgt", i), tgt0, vecs[i].tgt);
         check($sformatf("vec%0d_flushIfId", i), {31'b0, fif0}, {31'b0, vecs[i].fif});
         check($sformatf("vec%0d_flushIdEx", i), {31'b0, fex0}, {31'b0, vecs[i].fex});
         check($sformatf("vec%0d_mis", i), {31'b0, mis0}, {31'b0, vecs[i].mis});
         check($sformatf("vec%0d_busy", i), {31'b0, busy0}, 0);
         step();
         clearIn();
         repeat (4) step();
      end

      // Issue, one FLUSH cycle, back to IDLE
      doReset();
      drive(32'h100, 32'h20);
      #1;
      check("A_issue_rv", {31'b0, rv0}, 1);
      step();
      clearIn();
      #1;
      check("A_flush_fif", {31'b0, fif0}, 1);
      check("A_flush_fex", {31'b0, fex0}, 0);
      check("A_flush_rv", {31'b0, rv0}, 0);
      check("A_flush_busy", {31'b0, busy0}, 1);
      step();
      check("A_idle_fif", {31'b0, fif0}, 0);
      check("A_idle_busy", {31'b0, busy0}, 0);
      check("A_count", {16'b0, cnt0}, 1);

      // Misaligned target leaves the count alone
      branchValid = 1; branchTaken = 1; branchPc = 32'h100; branchImm = 32'h2;
      #1;
      check("C_mis", {31'b0, mis0}, 1);
      check("C_rv", {31'b0, rv0}, 0);
      step();
      clearIn();
      repeat (3) step();
      check("C_count", {16'b0, cnt0}, 1);

      // Stalled taken branch to address zero
      doReset();
      drive(32'h8, 32'hFFFFFFF8);
      stall = 1;
      #1;
      check("B_c0_rv", {31'b0, rv0}, 0);
      check("B_c0_fif", {31'b0, fif0}, 0);
      step();
      branchPc = 32'h40;
      for (int c = 1; c < 3; c++) begin
         check($sformatf("B_c%0d_busy", c), {31'b0, busy0}, 1);
         check($sformatf("B_c%0d_rv", c), {31'b0, rv0}, 0);
         check($sformatf("B_c%0d_fif", c), {31'b0, fif0}, 0);
         step();
      end
      stall = 0;
      #1;
      check("B_rel_rv", {31'b0, rv0}, 1);
      check("B_rel_tgt", tgt0, 32'h0);
      check("B_rel_fif", {31'b0, fif0}, 1);
      check("B_rel_fex", {31'b0, fex0}, 1);
      step();
      clearIn();
      repeat (3) step();

      // Reset asserted while holding a redirect
      doReset();
      drive(32'h200, 32'h40);
      stall = 1;
      step();
      check("D_hold_busy", {31'b0, busy0}, 1);
      check("D_hold_tgt", tgt0, 32'h240);
      rst_n = 0;
      stall = 0;
      #1;
      check("D_rst_rv", {31'b0, rv0}, 0);
      check("D_rst_fif", {31'b0, fif0}, 0);
      check("D_rst_fex", {31'b0, fex0}, 0);
      check("D_rst_busy", {31'b0, busy0}, 0);
      check("D_rst_tgt", tgt0, 32'h0);
      step();
      clearIn();
      rst_n = 1;
      leaked = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (rv0 || fif0 || busy0) leaked++;
         step();
      end
      check("D_no_redirect", leaked, 0);

      // FLUSH_CYCLES=3 with a stalled FLUSH cycle and a wrong-path branch
      doReset();
      ifCount = 0;
      rvExtra = 0;
      for (int c = 0; c < 7; c++) begin
         clearIn();
         if (c == 0) drive(32'h300, 32'h10);
         if (c >= 1 && c <= 3) drive(32'h500, 32'h10);
         if (c == 2) stall = 1;
         #1;
         if (fif1) ifCount++;
         if (c > 0 && (rv1 || fex1)) rvExtra++;
         if (c == 0) check("E_issue_rv", {31'b0, rv1}, 1);
         step();
      end
      check("E_flush_cycles", ifCount, 4);
      check("E_ignored_branch", rvExtra, 0);
      check("E_count", {30'b0, cnt1}, 1);

      // Counter saturation on the 2-bit instance
      doReset();
      for (int i = 0; i < 5; i++) begin
         drive(32'h1000, 32'h10);
         #1;
         step();
         clearIn();
         repeat (3) step();
         if (i == 3) check("F_count_after4", {30'b0, cnt1}, 3);
      end
      check("F_count_sat", {30'b0, cnt1}, 3);
      check("F_count_wide", {16'b0, cnt0}, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
